// File: rtl/grid_sel_pkg.sv
// Shared types for the shape-menu cursor: FSM states, button actions and the
// index-width helper used to size cursor and selection signals.
package grid_sel_pkg;

    typedef enum logic {
        StBrowse,
        StConfirmed
    } state_e;

    typedef enum logic [2:0] {
        ActNone,
        ActEnter,
        ActCancel,
        ActUp,
        ActDown,
        ActLeft,
        ActRight
    } action_e;

    // Bit positions of the buttons inside the edge-detector vector.
    localparam int unsigned NUM_BTNS   = 6;
    localparam int unsigned BTN_ENTER  = 0;
    localparam int unsigned BTN_CANCEL = 1;
    localparam int unsigned BTN_UP     = 2;
    localparam int unsigned BTN_DOWN   = 3;
    localparam int unsigned BTN_LEFT   = 4;
    localparam int unsigned BTN_RIGHT  = 5;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/grid_cursor_select_btn_edge.sv
// Rising-edge detector for a vector of debounced button levels; history
// clears on reset so a button held through reset release counts as a press.
module btn_edge #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/grid_cursor_select.sv
// Cursor-driven selection border for a COLS x ROWS menu grid: buttons move a
// cursor, enter/cancel latch a selection, and the drawn box follows at frame ticks.
module grid_cursor_select
    import grid_sel_pkg::*;
#(
    parameter int unsigned COLS         = 3,
    parameter int unsigned ROWS         = 3,
    parameter int unsigned CELL_W       = 214,
    parameter int unsigned CELL_H       = 146,
    parameter int unsigned INSET_X      = 4,
    parameter int unsigned INSET_Y      = 3,
    parameter int unsigned BORDER       = 2,
    parameter int unsigned BLINK_FRAMES = 15,
    parameter int unsigned WRAP         = 1,
    localparam int unsigned IW          = idx_width(COLS * ROWS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    HCount,
    input  logic [9:0]    VCount,
    input  logic          frame_tick,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_enter,
    input  logic          btn_cancel,
    output logic          bordeSelec_on,
    output logic [IW-1:0] sel_index,
    output logic          sel_valid
);

    localparam int unsigned CW = idx_width(COLS);
    localparam int unsigned RW = idx_width(ROWS);
    localparam int unsigned BW = idx_width(BLINK_FRAMES);

    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_rise;

    assign btn_level = {btn_right, btn_left, btn_down, btn_up, btn_cancel, btn_enter};

    btn_edge #(
        .WIDTH(NUM_BTNS)
    ) u_btn_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .level(btn_level),
        .rise (btn_rise)
    );

    state_e        state_q, state_d;
    action_e       action;
    logic [CW-1:0] col_q, col_d, disp_col_q, disp_col_d;
    logic [RW-1:0] row_q, row_d, disp_row_q, disp_row_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          border_q, border_d;

    // Only the highest-priority press of the cycle is acted upon.
    always_comb begin
        action = ActNone;
        if (btn_rise[BTN_ENTER]) begin
            action = ActEnter;
        end else if (btn_rise[BTN_CANCEL]) begin
            action = ActCancel;
        end else if (btn_rise[BTN_UP]) begin
            action = ActUp;
        end else if (btn_rise[BTN_DOWN]) begin
            action = ActDown;
        end else if (btn_rise[BTN_LEFT]) begin
            action = ActLeft;
        end else if (btn_rise[BTN_RIGHT]) begin
            action = ActRight;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (action)
            ActEnter: begin
                if (state_q == StBrowse) state_d = StConfirmed;
            end
            ActCancel: begin
                if (state_q == StConfirmed) state_d = StBrowse;
            end
            ActUp: begin
                if (state_q == StBrowse) begin
                    if (row_q != '0) row_d = row_q - RW'(1);
                    else if (WRAP != 0) row_d = RW'(ROWS - 1);
                end
            end
            ActDown: begin
                if (state_q == StBrowse) begin
                    if (row_q != RW'(ROWS - 1)) row_d = row_q + RW'(1);
                    else if (WRAP != 0) row_d = '0;
                end
            end
            ActLeft: begin
                if (state_q == StBrowse) begin
                    if (col_q != '0) col_d = col_q - CW'(1);
                    else if (WRAP != 0) col_d = CW'(COLS - 1);
                end
            end
            ActRight: begin
                if (state_q == StBrowse) begin
                    if (col_q != CW'(COLS - 1)) col_d = col_q + CW'(1);
                    else if (WRAP != 0) col_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Blink timing restarts from a visible phase every time CONFIRMED is entered.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        disp_col_d  = disp_col_q;
        disp_row_d  = disp_row_q;
        if (state_q == StBrowse) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
        if (frame_tick) begin
            disp_col_d = col_q;
            disp_row_d = row_q;
        end
    end

    logic [11:0] hc, vc, x0, x1, y0, y1;
    logic        in_box, near_edge, visible;

    always_comb begin
        hc = {2'b00, HCount};
        vc = {2'b00, VCount};
        x0 = 12'(disp_col_q) * 12'(CELL_W) + 12'(INSET_X);
        x1 = (12'(disp_col_q) + 12'd1) * 12'(CELL_W) - 12'(INSET_X) - 12'd1;
        y0 = 12'(disp_row_q) * 12'(CELL_H) + 12'(INSET_Y);
        y1 = (12'(disp_row_q) + 12'd1) * 12'(CELL_H) - 12'(INSET_Y) - 12'd1;
        in_box    = (hc >= x0) && (hc <= x1) && (vc >= y0) && (vc <= y1);
        // Far-edge tests are rearranged as additions so x1 - BORDER cannot underflow.
        near_edge = (hc < x0 + 12'(BORDER)) || (hc + 12'(BORDER) > x1) ||
                    (vc < y0 + 12'(BORDER)) || (vc + 12'(BORDER) > y1);
        visible   = (state_q == StBrowse) || phase_q;
        border_d  = in_box && near_edge && visible;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StBrowse;
            col_q       <= '0;
            row_q       <= '0;
            disp_col_q  <= '0;
            disp_row_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            border_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            disp_col_q  <= disp_col_d;
            disp_row_q  <= disp_row_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            border_q    <= border_d;
        end
    end

    assign bordeSelec_on = border_q;
    assign sel_index     = IW'(row_q) * IW'(COLS) + IW'(col_q);
    assign sel_valid     = (state_q == StConfirmed);

endmodule

// File: tb/tb_grid_cursor_select.sv
// Bench for grid_cursor_select: wrapping and saturating instances share stimulus
// and are checked every cycle against a behavioural model of the menu cursor.
module tb_grid_cursor_select;

    localparam int COLS = 3, ROWS = 3, CELL_W = 214, CELL_H = 146;
    localparam int INSET_X = 4, INSET_Y = 3, BORDER = 2, BF = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hcount = '0, vcount = '0;
    logic       frame_tick = 1'b0;
    logic [5:0] btn = '0;  // enter, cancel, up, down, left, right
    logic       bord_a, bord_b, val_a, val_b;
    logic [3:0] idx_a, idx_b;

    always #5 clk = ~clk;

    grid_cursor_select #(.WRAP(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .HCount(hcount), .VCount(vcount), .frame_tick(frame_tick),
        .btn_up(btn[2]), .btn_down(btn[3]), .btn_left(btn[4]), .btn_right(btn[5]),
        .btn_enter(btn[0]), .btn_cancel(btn[1]),
        .bordeSelec_on(bord_a), .sel_index(idx_a), .sel_valid(val_a)
    );

    grid_cursor_select #(.WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .HCount(hcount), .VCount(vcount), .frame_tick(frame_tick),
        .btn_up(btn[2]), .btn_down(btn[3]), .btn_left(btn[4]), .btn_right(btn[5]),
        .btn_enter(btn[0]), .btn_cancel(btn[1]),
        .bordeSelec_on(bord_b), .sel_index(idx_b), .sel_valid(val_b)
    );

    // Model state, index 0 = wrapping instance, 1 = saturating instance.
    int m_col[2], m_row[2], m_conf[2], m_cnt[2], m_vis[2], m_dcol[2], m_drow[2], m_bord[2];
    int m_prev[6];
    int n_checks = 0, n_fail = 0;

    typedef struct {int x; int y; int exp;} pix_vec_t;
    pix_vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int border_pixel(int dc, int dr, int x, int y, int vis);
        int x0 = dc * CELL_W + INSET_X, x1 = (dc + 1) * CELL_W - INSET_X - 1;
        int y0 = dr * CELL_H + INSET_Y, y1 = (dr + 1) * CELL_H - INSET_Y - 1;
        int d;
        if (x < x0 || x > x1 || y < y0 || y > y1) return 0;
        d = x - x0;
        if (x1 - x < d) d = x1 - x;
        if (y - y0 < d) d = y - y0;
        if (y1 - y < d) d = y1 - y;
        return (d < BORDER && vis != 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_col[w] = 0; m_row[w] = 0; m_conf[w] = 0; m_cnt[w] = 0; m_vis[w] = 1;
            m_dcol[w] = 0; m_drow[w] = 0; m_bord[w] = 0;
        end
        for (int i = 0; i < 6; i++) m_prev[i] = 0;
    endtask

    task automatic model_edge();
        int press = -1;
        for (int i = 0; i < 6; i++)
            if (press < 0 && btn[i] && m_prev[i] == 0) press = i;
        for (int w = 0; w < 2; w++) begin
            int nc = m_col[w], nr = m_row[w];
            m_bord[w] = border_pixel(m_dcol[w], m_drow[w], int'(hcount), int'(vcount),
                                     (m_conf[w] == 0 || m_vis[w] != 0) ? 1 : 0);
            if (m_conf[w] != 0 && frame_tick) begin
                if (m_cnt[w] == BF - 1) begin m_cnt[w] = 0; m_vis[w] = 1 - m_vis[w]; end
                else m_cnt[w]++;
            end
            if (frame_tick) begin m_dcol[w] = m_col[w]; m_drow[w] = m_row[w]; end
            if (press == 0 && m_conf[w] == 0) begin m_conf[w] = 1; m_cnt[w] = 0; m_vis[w] = 1; end
            else if (press == 1 && m_conf[w] != 0) m_conf[w] = 0;
            else if (press >= 2 && m_conf[w] == 0) begin
                if (press == 2) nr--;
                if (press == 3) nr++;
                if (press == 4) nc--;
                if (press == 5) nc++;
                if (nc < 0 || nc >= COLS) nc = (w == 0) ? (nc + COLS) % COLS : m_col[w];
                if (nr < 0 || nr >= ROWS) nr = (w == 0) ? (nr + ROWS) % ROWS : m_row[w];
                m_col[w] = nc; m_row[w] = nr;
            end
        end
        for (int i = 0; i < 6; i++) m_prev[i] = btn[i] ? 1 : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("border_wrap", bord_a, m_bord[0]);
        chk("index_wrap", idx_a, m_row[0] * COLS + m_col[0]);
        chk("valid_wrap", val_a, m_conf[0]);
        chk("border_sat", bord_b, m_bord[1]);
        chk("index_sat", idx_b, m_row[1] * COLS + m_col[1]);
        chk("valid_sat", val_b, m_conf[1]);
    endtask

    task automatic press(input int i);
        btn[i] = 1'b1; step(); btn[i] = 1'b0; step();
    endtask

    task automatic tick();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input int exp, input string name);
        hcount = 10'(x); vcount = 10'(y); step(); chk(name, bord_a, exp);
    endtask

    // Called at a negedge: async reset must clear outputs without a clock edge.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_border", bord_a, 0);
        chk("rst_index", idx_a, 0);
        chk("rst_valid", val_a, 0);
        chk("rst_index_sat", idx_b, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{4, 3, 1};   vecs[1] = '{5, 3, 1};   vecs[2] = '{209, 142, 1};
        vecs[3] = '{4, 100, 1}; vecs[4] = '{6, 6, 0};   vecs[5] = '{3, 3, 0};
        vecs[6] = '{210, 3, 0};
        model_reset();
        @(negedge clk);
        reset_pulse();

        // Default cell 0 after the first frame tick.
        tick();
        foreach (vecs[i]) pix(vecs[i].x, vecs[i].y, vecs[i].exp, "cell0_pixel");

        // Move to (2,1); box only follows after a tick; then wrap right.
        press(5); press(5); press(3);
        chk("index_moved", idx_a, 5);
        pix(432, 149, 0, "before_tick");
        tick();
        pix(432, 149, 1, "cell5_tl");
        pix(637, 288, 1, "cell5_br");
        pix(431, 149, 0, "cell5_outside");
        pix(4, 3, 0, "cell0_cleared");
        press(5);
        chk("wrap_right", idx_a, 3);
        chk("sat_right", idx_b, 5);

        // Edge handling at (0,0) and a long held button.
        reset_pulse();
        press(4); press(2);
        chk("sat_left_up", idx_b, 0);
        chk("wrap_left_up", idx_a, 8);
        btn[3] = 1'b1;
        repeat (100) step();
        btn[3] = 1'b0;
        step();
        chk("held_down_sat", idx_b, 3);
        chk("held_down_wrap", idx_a, 2);

        // Enter beats right; blink over 60 frames; cancel restores steady border.
        reset_pulse();
        press(5);
        tick();
        btn[0] = 1'b1; btn[5] = 1'b1; step(); btn = '0; step();
        chk("enter_valid", val_a, 1);
        chk("enter_index", idx_a, 1);
        hcount = 10'd218; vcount = 10'd3;
        for (int k = 1; k <= 60; k++) begin
            tick(); step();
            chk("blink", bord_a, ((k / BF) % 2 == 0) ? 1 : 0);
        end
        press(5);
        chk("frozen_index", idx_a, 1);
        press(1);
        chk("cancel_valid", val_a, 0);
        for (int k = 0; k < 20; k++) begin
            tick(); step();
            chk("steady", bord_a, 1);
        end

        // Press on the tick cycle: old position drawn for that frame.
        btn[5] = 1'b1; frame_tick = 1'b1; step(); btn = '0; frame_tick = 1'b0;
        chk("tick_press_index", idx_a, 2);
        pix(218, 3, 1, "old_pos_kept");
        pix(432, 3, 0, "new_pos_waits");
        tick();
        pix(432, 3, 1, "new_pos_drawn");
        pix(218, 3, 0, "old_pos_gone");

        // Reset while confirmed at index 8.
        press(3); press(3); press(0);
        chk("conf8_valid", val_a, 1);
        chk("conf8_index", idx_a, 8);
        hcount = 10'd432; vcount = 10'd295;
        repeat (3) tick();
        reset_pulse();
        tick();
        pix(4, 3, 1, "cell0_after_reset");

        // Randomised traffic; occasional resets with buttons left held.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 6; i++)
                if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
            frame_tick = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0) begin
                hcount = 10'(m_dcol[0] * CELL_W + int'($urandom_range(0, CELL_W - 1)));
                vcount = 10'(m_drow[0] * CELL_H + int'($urandom_range(0, CELL_H - 1)));
            end else begin
                hcount = 10'($urandom_range(0, 1023));
                vcount = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 699) == 0) reset_pulse();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
